// File: rtl/fifo_seq_checker.sv
// Read-side checker for the fill/drain FIFO test: drains the FIFO once it is full and checks each burst is 0,1,2,... of length DEPTH.
// Optional first-mismatch capture ports are built when FIFO_CHK_CAPTURE_EN is defined.
module fifo_seq_checker #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_full,
  input  logic                       fifo_empty,
  input  logic [DATA_W-1:0]          fifo_dout,
  output logic                       fifo_rd_en,
  output logic                       chk_active,
  output logic [$clog2(DEPTH+1)-1:0] word_cnt,
  output logic                       burst_done,
  output logic                       burst_ok,
  output logic [CNT_W-1:0]           burst_cnt,
  output logic [CNT_W-1:0]           err_cnt
`ifdef FIFO_CHK_CAPTURE_EN
  ,
  output logic                       first_err_vld,
  output logic [DATA_W-1:0]          first_err_exp,
  output logic [DATA_W-1:0]          first_err_act
`endif
);

  localparam int unsigned WC_W  = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 2;

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, REPORT} state_t;

  state_t              state_q, state_d;
  logic                rd_vld_q;
  logic [DATA_W-1:0]   exp_q;
  logic [WC_W-1:0]     word_cnt_q;
  logic                bad_q;
  logic                ovr_q;
  logic [CNT_W-1:0]    err_q, err_d;
  logic [CNT_W-1:0]    burst_cnt_q;
  logic                done_q;
  logic                ok_q;
  logic                active_q;

  logic                start_c;
  logic                rpt_c;
  logic                data_err_c;
  logic                ovr_c;
  logic                len_err_c;
  logic [WC_W-1:0]     wc_nxt_c;
  logic                bad_nxt_c;
  logic                ovr_nxt_c;
  logic [SUM_W-1:0]    err_sum_c;

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fifo_full) state_d = DRAIN;
      DRAIN:   if (fifo_empty) state_d = FLUSH;
      FLUSH:   state_d = REPORT;
      default: state_d = IDLE;
    endcase
  end

  assign fifo_rd_en = (state_q == DRAIN) && !fifo_empty;
  assign start_c    = (state_q == IDLE) && fifo_full;
  assign rpt_c      = (state_q == FLUSH);

  // Compare of the word read last cycle, plus the end-of-burst length verdict
  always_comb begin
    data_err_c = rd_vld_q && (fifo_dout != exp_q);
    ovr_c      = rd_vld_q && (word_cnt_q == WC_W'(DEPTH));
    wc_nxt_c   = (rd_vld_q && !ovr_c) ? word_cnt_q + WC_W'(1) : word_cnt_q;
    bad_nxt_c  = bad_q | data_err_c | ovr_c;
    ovr_nxt_c  = ovr_q | ovr_c;
    len_err_c  = (wc_nxt_c != WC_W'(DEPTH)) || ovr_nxt_c;
    err_sum_c  = SUM_W'(err_q) + SUM_W'(data_err_c) + SUM_W'(rpt_c && len_err_c);
    if (err_sum_c > SUM_W'({CNT_W{1'b1}})) err_d = {CNT_W{1'b1}};
    else                                   err_d = err_sum_c[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_vld_q    <= 1'b0;
      exp_q       <= '0;
      word_cnt_q  <= '0;
      bad_q       <= 1'b0;
      ovr_q       <= 1'b0;
      err_q       <= '0;
      burst_cnt_q <= '0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_vld_q <= fifo_rd_en;
      err_q    <= err_d;
      done_q   <= rpt_c;
      active_q <= (state_d == DRAIN) || (state_d == FLUSH);
      if (start_c) begin
        exp_q      <= '0;
        word_cnt_q <= '0;
        bad_q      <= 1'b0;
        ovr_q      <= 1'b0;
      end else if (rd_vld_q) begin
        exp_q      <= exp_q + DATA_W'(1);
        word_cnt_q <= wc_nxt_c;
        bad_q      <= bad_nxt_c;
        ovr_q      <= ovr_nxt_c;
      end
      if (rpt_c) begin
        ok_q        <= !bad_nxt_c && !len_err_c;
        burst_cnt_q <= burst_cnt_q + CNT_W'(1);
      end
    end
  end

  assign chk_active = active_q;
  assign word_cnt   = word_cnt_q;
  assign burst_done = done_q;
  assign burst_ok   = ok_q;
  assign burst_cnt  = burst_cnt_q;
  assign err_cnt    = err_q;

`ifdef FIFO_CHK_CAPTURE_EN
  logic              fe_vld_q;
  logic [DATA_W-1:0] fe_exp_q;
  logic [DATA_W-1:0] fe_act_q;

  // Latch only the first mismatch seen since reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fe_vld_q <= 1'b0;
      fe_exp_q <= '0;
      fe_act_q <= '0;
    end else if (data_err_c && !fe_vld_q) begin
      fe_vld_q <= 1'b1;
      fe_exp_q <= exp_q;
      fe_act_q <= fifo_dout;
    end
  end

  assign first_err_vld = fe_vld_q;
  assign first_err_exp = fe_exp_q;
  assign first_err_act = fe_act_q;
`endif

endmodule

// File: tb/tb_fifo_seq_checker.sv
// Bench for fifo_seq_checker: behavioural FIFO plus a per-burst expectation model (8-bit data so exp wraps inside a burst).
module tb_fifo_seq_checker;

  localparam int DW    = 8;
  localparam int DEP   = 512;
  localparam int CW    = 4;
  localparam int WCW   = $clog2(DEP + 1);
  localparam int MEMSZ = 8192;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           fifo_full, fifo_empty;
  logic [DW-1:0]  fifo_dout = '0;
  logic           fifo_rd_en, chk_active, burst_done, burst_ok;
  logic [WCW-1:0] word_cnt;
  logic [CW-1:0]  burst_cnt, err_cnt;
`ifdef FIFO_CHK_CAPTURE_EN
  logic           first_err_vld;
  logic [DW-1:0]  first_err_exp, first_err_act;
`endif

  fifo_seq_checker #(.DATA_W(DW), .DEPTH(DEP), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .chk_active(chk_active),
    .word_cnt(word_cnt), .burst_done(burst_done), .burst_ok(burst_ok),
    .burst_cnt(burst_cnt), .err_cnt(err_cnt)
`ifdef FIFO_CHK_CAPTURE_EN
    , .first_err_vld(first_err_vld), .first_err_exp(first_err_exp),
    .first_err_act(first_err_act)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: stimulus owns wr_cnt/mem, the read side owns rd_cnt.
  logic [DW-1:0] mem [0:MEMSZ-1];
  int  wr_cnt = 0, rd_cnt = 0;
  bit  full_force = 1'b0, rd_seen = 1'b0;
  int  done_seen = 0, rd_empty_viol = 0;

  assign fifo_empty = (wr_cnt == rd_cnt);
  assign fifo_full  = ((wr_cnt - rd_cnt) >= DEP) || full_force;

  always @(negedge clk) begin
    rd_seen = fifo_rd_en;
    if (burst_done) done_seen++;
    if (fifo_rd_en && fifo_empty) rd_empty_viol++;
  end

  always @(posedge clk) begin
    if (rst) rd_cnt <= wr_cnt;
    else if (rd_seen) begin
      fifo_dout <= mem[rd_cnt % MEMSZ];
      rd_cnt    <= rd_cnt + 1;
    end
  end

  // Reference model state
  int            n_cmp = 0, n_fail = 0;
  int            m_err = 0, m_bcnt = 0, m_done = 0;
  bit            m_fv = 1'b0;
  logic [DW-1:0] m_fexp = '0, m_fact = '0;
  logic [DW-1:0] bd [0:1023];
  int            bn = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rd_en"}, 32'(fifo_rd_en), 0);
    check({tag, " active"}, 32'(chk_active), 0);
    check({tag, " word_cnt"}, 32'(word_cnt), 0);
    check({tag, " done"}, 32'(burst_done), 0);
    check({tag, " ok"}, 32'(burst_ok), 0);
    check({tag, " burst_cnt"}, 32'(burst_cnt), 0);
    check({tag, " err_cnt"}, 32'(err_cnt), 0);
  endtask

  task automatic model_reset();
    m_err = 0; m_bcnt = 0; m_fv = 1'b0; m_fexp = '0; m_fact = '0;
  endtask

  task automatic prep(input int n);
    bn = n;
    for (int i = 0; i < n; i++) bd[i] = DW'(i);
  endtask

  task automatic commit();
    for (int i = 0; i < bn; i++) mem[(wr_cnt + i) % MEMSZ] = bd[i];
    wr_cnt += bn;
  endtask

  // Expected burst outcome computed straight from the burst contents
  task automatic run_burst(input string tag, input bit force_full);
    int de, le, nrd, exp_wc, got;
    bit exp_ok;
    de = 0;
    for (int i = 0; i < bn; i++)
      if (bd[i] != DW'(i)) begin
        de++;
        if (!m_fv) begin m_fv = 1'b1; m_fexp = DW'(i); m_fact = bd[i]; end
      end
    le     = (bn != DEP) ? 1 : 0;
    m_err  = (m_err + de + le > 2**CW - 1) ? 2**CW - 1 : m_err + de + le;
    exp_ok = (de == 0) && (le == 0);
    exp_wc = (bn < DEP) ? bn : DEP;
    m_bcnt = (m_bcnt + 1) % (2**CW);
    m_done++;

    @(negedge clk);
    commit();
    full_force = force_full;
    @(negedge clk);
    full_force = 1'b0;
    nrd = 0; got = 0;
    for (int c = 0; c < 4 * DEP && got == 0; c++) begin
      if (c > 0) @(negedge clk);
      if (fifo_rd_en) nrd++;
      if (burst_done) got = 1;
    end
    check({tag, " done seen"}, 32'(got), 1);
    check({tag, " reads"}, 32'(nrd), 32'(bn));
    check({tag, " ok"}, 32'(burst_ok), 32'(exp_ok));
    check({tag, " word_cnt"}, 32'(word_cnt), 32'(exp_wc));
    check({tag, " err_cnt"}, 32'(err_cnt), 32'(m_err));
    check({tag, " burst_cnt"}, 32'(burst_cnt), 32'(m_bcnt));
    check({tag, " active in report"}, 32'(chk_active), 0);
`ifdef FIFO_CHK_CAPTURE_EN
    check({tag, " fe_vld"}, 32'(first_err_vld), 32'(m_fv));
    check({tag, " fe_exp"}, 32'(first_err_exp), 32'(m_fexp));
    check({tag, " fe_act"}, 32'(first_err_act), 32'(m_fact));
`endif
    @(negedge clk);
    check({tag, " done one clk"}, 32'(burst_done), 0);
    check({tag, " ok holds"}, 32'(burst_ok), 32'(exp_ok));
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int nrd, r, nc, p;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("idle empty rd_en", 32'(fifo_rd_en), 0);

    prep(DEP);                                   run_burst("clean", 1'b0);
    prep(DEP); bd[100] = DW'(16'h00FF);          run_burst("corrupt100", 1'b0);
    prep(DEP - 1);                               run_burst("short511", 1'b1);
    for (int k = 0; k < 3; k++) begin prep(DEP); run_burst("b2b", 1'b0); end

    // Reset in the middle of a drain
    prep(DEP);
    @(negedge clk); commit();
    nrd = 0;
    for (int c = 0; c < 4 * DEP && nrd < 200; c++) begin
      @(negedge clk);
      if (fifo_rd_en) nrd++;
    end
    check("mid reads reached", 32'(nrd), 200);
    rst = 1'b1;
    #1;
    check_all_zero("mid reset");
    @(negedge clk); rst = 1'b0;
    model_reset();
    prep(DEP); run_burst("after reset", 1'b0);

    prep(DEP);
    for (int k = 0; k < 20; k++) bd[10 + 20 * k] = ~DW'(10 + 20 * k);
    run_burst("saturate", 1'b0);
    prep(DEP); run_burst("sat hold", 1'b0);

    do_reset();
    prep(DEP + 3); run_burst("overrun", 1'b0);
    prep(0);       run_burst("full+empty", 1'b1);

    do_reset();
    for (int k = 0; k < 8; k++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      prep(DEP);
      else if (r < 8) prep(DEP - 1 - $urandom_range(0, 4));
      else            prep(DEP + 1 + $urandom_range(0, 2));
      nc = $urandom_range(0, 3);
      for (int j = 0; j < nc; j++) begin
        p = $urandom_range(0, bn - 1);
        bd[p] = bd[p] ^ DW'($urandom_range(1, 2**DW - 1));
      end
      run_burst("random", bn < DEP);
    end

    check("burst_done pulses", 32'(done_seen), 32'(m_done));
    check("read while empty", 32'(rd_empty_viol), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
